// File: rtl/dmem_wbuf.sv
// Data memory with a posted write buffer and a maintenance read channel sharing the array's sync port.
// Define DMEM_FWD_EN to forward buffered stores to loads and debug reads instead of stalling loads.
module dmem_wbuf #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [31:0]   a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          mem_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ready,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata
);

    localparam int WORDS = 1 << AW;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] idx_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          dbg_rvalid_q;
    logic [31:0]   dbg_rdata_q;

    logic [AW-1:0] ld_idx;
    logic          full, empty, enq, drain;
    logic [31:0]   dbg_src;
    logic          unused_bits;

    assign ld_idx = a[AW+1:2];
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // Full test uses the start-of-cycle count, so a same-cycle drain never admits the store.
    assign enq    = we & ~full & reset;

`ifdef DMEM_FWD_EN
    logic          ld_hit, dbg_hit;
    logic [31:0]   ld_fwd, dbg_fwd;
    logic [PW-1:0] slot;

    assign unused_bits = ^{a[31:AW+2], a[1:0], re};
    assign dbg_ready   = reset & dbg_req & ~full;
    assign mem_stall   = reset & we & full;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_fwd  = '0;
        dbg_hit = 1'b0;
        dbg_fwd = '0;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (idx_q[slot] == ld_idx) begin
                    ld_hit = 1'b1;
                    ld_fwd = dat_q[slot];
                end
                if (idx_q[slot] == dbg_addr) begin
                    dbg_hit = 1'b1;
                    dbg_fwd = dat_q[slot];
                end
            end
        end
    end

    assign rd      = ld_hit  ? ld_fwd  : mem_q[ld_idx];
    assign dbg_src = dbg_hit ? dbg_fwd : mem_q[dbg_addr];
`else
    assign unused_bits = ^{a[31:AW+2], a[1:0]};
    // Without forwarding, loads and debug reads wait until every posted store has landed.
    assign dbg_ready   = reset & dbg_req & empty;
    assign mem_stall   = reset & ((we & full) | (re & ~empty));
    assign rd          = mem_q[ld_idx];
    assign dbg_src     = mem_q[dbg_addr];
`endif

    assign drain = ~empty & ~dbg_ready;

    always_comb begin
        count_d = count_q;
        if (enq && !drain)
            count_d = count_q + 1'b1;
        else if (!enq && drain)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            if (enq)
                tail_q <= tail_q + 1'b1;
            if (drain)
                head_q <= head_q + 1'b1;
            count_q      <= count_d;
            dbg_rvalid_q <= dbg_ready;
            if (dbg_ready)
                dbg_rdata_q <= dbg_src;
        end
    end

    // Buffer payload and array carry no reset; validity lives in count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            idx_q[tail_q] <= ld_idx;
            dat_q[tail_q] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (drain && reset)
            mem_q[idx_q[head_q]] <= dat_q[head_q];
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf; expectations follow the DMEM_FWD_EN setting of the build.
module tb_dmem_wbuf;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
`ifdef DMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [31:0]   a = '0;
    logic [31:0]   wd = '0;
    logic [31:0]   rd;
    logic          mem_stall;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_ready;
    logic          dbg_rvalid;
    logic [31:0]   dbg_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dmem_wbuf #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .we(we), .re(re), .a(a), .wd(wd), .rd(rd),
        .mem_stall(mem_stall), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with traffic on the inputs.
        dbg_req = 1'b1; dbg_addr = 8'h03; we = 1'b1; a = 32'h0000_000C; wd = 32'h1;
        tick(2); #2;
        chk1 ("rst_stall", mem_stall, 1'b0);
        chk1 ("rst_dbg_ready", dbg_ready, 1'b0);
        chk1 ("rst_rvalid", dbg_rvalid, 1'b0);
        chk32("rst_rdata", dbg_rdata, 32'h0);
        reset = 1'b1; we = 1'b0; dbg_req = 1'b0;

        // Preload word 3, then post a store to it and reset before it drains.
        tick(); we = 1'b1; a = 32'h0000_000C; wd = 32'h3333_3333;
        tick(); we = 1'b0;
        tick(2);
        we = 1'b1; wd = 32'h0BAD_0BAD; dbg_req = 1'b1; dbg_addr = 8'h03;
        #2 chk1("pre_rst_ready", dbg_ready, 1'b1);
        tick(); we = 1'b0; dbg_req = 1'b0;
        chk1 ("pre_rst_rvalid", dbg_rvalid, 1'b1);
        chk32("pre_rst_rdata", dbg_rdata, 32'h3333_3333);
        reset = 1'b0; re = 1'b1;
        #2;
        chk1 ("midrst_stall", mem_stall, 1'b0);
        chk1 ("midrst_rvalid", dbg_rvalid, 1'b0);
        chk32("midrst_rdata", dbg_rdata, 32'h0);
        chk32("midrst_rd", rd, 32'h3333_3333);
        tick(); reset = 1'b1;
        tick(); #2;
        chk1 ("dropped_stall", mem_stall, 1'b0);
        chk32("dropped_store", rd, 32'h3333_3333);
        re = 1'b0;

        // Store then immediate load of the same word.
        tick(); we = 1'b1; a = 32'h0000_0010; wd = 32'hDEAD_BEEF;
        tick(); we = 1'b0; re = 1'b1;
        #2;
`ifdef DMEM_FWD_EN
        chk32("fwd_rd", rd, 32'hDEAD_BEEF);
        chk1 ("fwd_stall", mem_stall, 1'b0);
`else
        chk1 ("nofwd_stall", mem_stall, 1'b1);
`endif
        tick(); #2;
        chk1 ("ld_stall_clear", mem_stall, 1'b0);
        chk32("ld_rd", rd, 32'hDEAD_BEEF);
        re = 1'b0;

        // Two stores to one word; youngest must win, in buffer and in array.
        tick(); we = 1'b1; a = 32'h0000_0020; wd = 32'h1; dbg_req = 1'b1; dbg_addr = 8'h55;
        tick(); wd = 32'h2;
        tick(); we = 1'b0; re = 1'b1;
`ifdef DMEM_FWD_EN
        #2 chk32("youngest_fwd_rd", rd, 32'h2);
`endif
        dbg_req = 1'b0;
        tick(4); #2;
        chk1 ("youngest_stall", mem_stall, 1'b0);
        chk32("youngest_rd", rd, 32'h2);
        re = 1'b0; dbg_req = 1'b1; dbg_addr = 8'h08;
        tick(); dbg_req = 1'b0;
        chk1 ("youngest_dbg_rvalid", dbg_rvalid, 1'b1);
        chk32("youngest_dbg_rdata", dbg_rdata, 32'h2);
        tick(); #2 chk1("rvalid_pulse", dbg_rvalid, 1'b0);

        // DEPTH+1 stores with debug held: fill, stall, forced drain.
        dbg_req = 1'b1; dbg_addr = 8'h7F;
        for (int i = 0; i < DEPTH + 1; i++) begin
            we = 1'b1; a = 32'h40 + 32'(4 * i); wd = 32'h100 + 32'(i);
            #2;
            chk1("fill_stall", mem_stall, FWD ? (i == DEPTH) : 1'b0);
            chk1("fill_ready", dbg_ready, FWD ? (i != DEPTH) : (i == 0));
            tick();
        end
`ifdef DMEM_FWD_EN
        #2;
        chk1("retry_stall", mem_stall, 1'b0);
        chk1("retry_ready", dbg_ready, 1'b1);
        tick();
`endif
        we = 1'b0; dbg_req = 1'b0;
        tick(6); re = 1'b1; a = 32'h50;
        #2 chk32("fill_last", rd, 32'h104);
        a = 32'h40;
        #1 chk32("fill_first", rd, 32'h100);
        re = 1'b0;

        // Plain debug read from the array.
        tick(); we = 1'b1; a = 32'h80; wd = 32'h1234_5678;
        tick(); we = 1'b0;
        tick(2);
        dbg_req = 1'b1; dbg_addr = 8'h20;
        #2 chk1("dbg_ready", dbg_ready, 1'b1);
        tick(); dbg_req = 1'b0;
        #2;
        chk1 ("dbg_rvalid", dbg_rvalid, 1'b1);
        chk32("dbg_rdata", dbg_rdata, 32'h1234_5678);
        tick(); #2 chk1("dbg_rvalid_drop", dbg_rvalid, 1'b0);

        // Debug read of a word that is still buffered.
        tick(); we = 1'b1; a = 32'h84; wd = 32'hCAFE_F00D; dbg_req = 1'b1; dbg_addr = 8'h30;
        tick(); we = 1'b0; dbg_addr = 8'h21;
        #2;
`ifdef DMEM_FWD_EN
        chk1("dbgfwd_ready", dbg_ready, 1'b1);
        tick(); dbg_req = 1'b0;
        #2;
`else
        chk1("dbgwait_ready0", dbg_ready, 1'b0);
        tick(); #2;
        chk1("dbgwait_ready1", dbg_ready, 1'b1);
        tick(); dbg_req = 1'b0;
`endif
        chk1 ("dbgbuf_rvalid", dbg_rvalid, 1'b1);
        chk32("dbgbuf_rdata", dbg_rdata, 32'hCAFE_F00D);

        // Address aliasing modulo 2**AW words.
        tick(); we = 1'b1; a = 32'h400; wd = 32'hA5;
        tick(); we = 1'b0; re = 1'b1; a = 32'h0;
        #2;
`ifdef DMEM_FWD_EN
        chk32("alias_fwd_rd", rd, 32'hA5);
`else
        chk1("alias_stall", mem_stall, 1'b1);
`endif
        tick(2); #2;
        chk1 ("alias_stall_clear", mem_stall, 1'b0);
        chk32("alias_rd", rd, 32'hA5);
        re = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
# dmem_wbuf

Data-memory responder for the single-cycle datapath's load/store port. It answers the `aluout`/`writedata`/`readdata` interface: loads return data combinationally, and stores are absorbed into a small posted write buffer. A shared single-port maintenance (debug/DMA) read channel and the buffer drain compete for the array's synchronous port. The processor's control unit gates `pc` update with `mem_stall`.

## Interface
- `AW`, 8: word-address width; array holds 2**AW 32-bit words.
- `DEPTH`, 4: write-buffer entries; power of two, 2..16.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `we` input 1: store request from the datapath (memwrite).
- `re` input 1: load request (memtoreg); used only for stall generation.
- `a` input 32: byte address (aluout); word index = `a[AW+1:2]`; `a[1:0]` and `a[31:AW+2]` are ignored, so addresses alias modulo 2**AW words.
- `wd` input 32: store data (writedata).
- `rd` output 32: load data (readdata), combinational.
- `mem_stall` output 1: the current access is not accepted; hold the PC.
- `dbg_req` input 1: maintenance read request.
- `dbg_addr` input AW: maintenance word address.
- `dbg_ready` output 1: `dbg_req` is accepted this cycle.
- `dbg_rvalid` output 1: `dbg_rdata` is valid (one-cycle pulse).
- `dbg_rdata` output 32: maintenance read data.

## Operation
- The buffer is a FIFO of {word index, data} entries with a count of 0..DEPTH. There is no merging; repeated stores to one address occupy separate entries.
- Enqueue happens when `we` is high and count < DEPTH; the entry is written at the clock edge.
- Full case: when `we` is high and count == DEPTH, `mem_stall` is 1 and nothing is enqueued. The full test uses the count at the start of the cycle, so a same-cycle drain does not admit the store.
- Drain (sync port): if count > 0 and the port is granted to drain, the oldest entry is written to the array at the edge and count decrements. Enqueue and drain in the same cycle leave count unchanged.
- Port arbitration:
  - If count == DEPTH, drain wins; `dbg_ready` = 0.
  - Otherwise, if `dbg_req` is high, debug wins (`dbg_ready` = 1) and drain idles that cycle.
  - Otherwise, drain.
- Loads: `rd` = the data of the youngest buffer entry whose index matches `a`, else the array word. Entries enqueued at the current edge are not visible until the next cycle.
- Debug read: on `dbg_ready`, the array is read at the edge. `dbg_rdata` returns the youngest matching buffer entry captured in the request cycle, else the array word. `dbg_rvalid` = 1 for exactly the following cycle.
- Buffer state does not feed back to the datapath beyond `mem_stall`; the datapath sees stores as committed immediately.

## Timing
- Load latency: 0 cycles (combinational `rd`). Store accept: same edge.
- Debug read: request at edge N accepted, `dbg_rvalid`/`dbg_rdata` after edge N+1. Back-to-back requests are allowed every cycle.
- Worst-case debug wait: one cycle per full-buffer drain.
- Reset asserted:
  - count = 0 and all entries are invalid (pending stores are discarded).
  - `mem_stall` = 0, `dbg_ready` = 0, `dbg_rvalid` = 0, `dbg_rdata` = 0.
  - `rd` reflects the array.
  - Array contents are not reset.
- Reset mid-drain: the in-flight array write is suppressed.

## Configuration
- `DMEM_FWD_EN` defined:
  - Store-to-load and store-to-debug forwarding as described.
  - `mem_stall` depends only on `we` and full.
- `DMEM_FWD_EN` undefined:
  - No forwarding comparators.
  - `rd`/`dbg_rdata` come from the array only.
  - `mem_stall` is also 1 when `re` is high and count > 0, until the buffer empties.
  - A debug request while count > 0 gets `dbg_ready` = 0.

## Test plan
- Reset with `reset` = 0 mid-traffic → count 0, `mem_stall` 0, `dbg_rvalid` 0, `dbg_rdata` 0x0; a pending store to word 3 never reaches the array.
- Store 0xDEADBEEF to `a` = 0x10, load `a` = 0x10 next cycle (FWD_EN) → `rd` = 0xDEADBEEF while the entry is still buffered; without FWD_EN → `mem_stall` = 1 for one cycle, then `rd` = 0xDEADBEEF.
- Stores 0x1, 0x2 to the same address, then a load → `rd` = 0x2 (youngest wins); after drain the array holds 0x2.
- Hold `dbg_req` = 1 continuously while issuing DEPTH+1 stores → buffer fills, 5th store sees `mem_stall` = 1, one drain occurs with `dbg_ready` = 0, the store is then accepted.
- Debug read of word 0x20 (array 0x12345678, no buffered match) → `dbg_rvalid` pulses one cycle later with 0x12345678.
- Address aliasing with AW = 8: store 0xA5 to `a` = 0x400, load `a` = 0x000 → `rd` = 0xA5.
